// File: rtl/pkg_naped.sv
// rtl/pkg_naped.sv - shared drive constants and move FSM state encoding
package pkg_naped;

    localparam int         KATY_NA_OBROT  = 360;
    localparam logic [8:0] OKRES_NIEWAZNY = 9'h1FF;

    localparam logic KIER_CW  = 1'b1;
    localparam logic KIER_CCW = 1'b0;

    typedef enum logic [1:0] {
        SPOCZYNEK,
        RUCH,
        PAUZA
    } stan_t;

endpackage

// File: rtl/licznik_okresu.sv
// rtl/licznik_okresu.sv - loadable tick counter with period latch and end-of-degree strobe
module licznik_okresu #(
    parameter int SZER = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            zaladuj,
    input  logic            wlacz,
    input  logic [SZER-1:0] okres_we,
    output logic            koniec_stopnia
);

    logic [SZER-1:0] okres;
    logic [SZER-1:0] licznik;

    assign koniec_stopnia = wlacz && (licznik == (okres - 1'b1));

    // A load always restarts the degree from zero ticks, even when it coincides with a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            okres   <= '0;
            licznik <= '0;
        end else if (zaladuj) begin
            okres   <= okres_we;
            licznik <= '0;
        end else if (wlacz) begin
            licznik <= koniec_stopnia ? '0 : licznik + 1'b1;
        end
    end

endmodule

// File: rtl/generator_krokow_katowych.sv
// rtl/generator_krokow_katowych.sv - per-degree step pulse generator with angle tracking; ROZRUCH_EN adds a doubled-period start ramp
module generator_krokow_katowych #(
    parameter int SZER_OKRESU   = 9,
    parameter int KATY_NA_OBROT = pkg_naped::KATY_NA_OBROT
`ifdef ROZRUCH_EN
    ,
    parameter int RAMPA_STOPNIE = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SZER_OKRESU-1:0] taktowanie_na_stopien,
    input  logic                   start,
    input  logic                   kierunek,
    input  logic [8:0]             kat_zadany,
    output logic                   gotowy,
    output logic                   krok,
    output logic                   kierunek_wy,
    output logic [8:0]             kat_aktualny,
    output logic                   koniec,
    output logic                   wstrzymany
);

    localparam logic [8:0] KAT_MAX   = 9'(KATY_NA_OBROT - 1);
    localparam logic [8:0] KAT_PELNY = 9'(KATY_NA_OBROT);
`ifdef ROZRUCH_EN
    localparam int SZER_LICZ = SZER_OKRESU + 1;
`else
    localparam int SZER_LICZ = SZER_OKRESU;
`endif

    pkg_naped::stan_t     stan;
    logic [8:0]           pozostalo;
    logic [8:0]           kat_obciety;
    logic [8:0]           kat_nast;
    logic                 okres_ok;
    logic                 przyjmij;
    logic                 wyjscie_pauzy;
    logic                 wlacz;
    logic                 zaladuj;
    logic                 koniec_stopnia;
    logic [SZER_LICZ-1:0] okres_nast;

    assign okres_ok      = (taktowanie_na_stopien != '0) && !(&taktowanie_na_stopien);
    assign przyjmij      = (stan == pkg_naped::SPOCZYNEK) && gotowy && start && (kat_zadany != 9'd0);
    assign wyjscie_pauzy = (stan == pkg_naped::PAUZA) && okres_ok;
    assign wlacz         = (stan == pkg_naped::RUCH);
    // Period is re-sampled at every degree boundary, so mid-degree changes wait for the next degree.
    assign zaladuj       = przyjmij || wyjscie_pauzy || koniec_stopnia;
    assign kat_obciety   = (kat_zadany > KAT_PELNY) ? KAT_PELNY : kat_zadany;

`ifdef ROZRUCH_EN
    localparam int                    SZER_RAMPY   = $clog2(RAMPA_STOPNIE + 2);
    localparam logic [SZER_RAMPY-1:0] RAMPA_KONIEC = SZER_RAMPY'(RAMPA_STOPNIE);

    logic [SZER_RAMPY-1:0] rampa;
    logic [SZER_RAMPY-1:0] rampa_idx;

    // rampa counts completed degrees of this move; rampa_idx is the index of the degree being loaded.
    always_comb begin
        rampa_idx = rampa;
        if (przyjmij) begin
            rampa_idx = '0;
        end else if (koniec_stopnia && (rampa != RAMPA_KONIEC)) begin
            rampa_idx = rampa + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rampa <= '0;
        end else begin
            rampa <= rampa_idx;
        end
    end

    assign okres_nast = (rampa_idx < RAMPA_KONIEC) ? {taktowanie_na_stopien, 1'b0}
                                                   : {1'b0, taktowanie_na_stopien};
`else
    assign okres_nast = taktowanie_na_stopien;
`endif

    always_comb begin
        kat_nast = kat_aktualny;
        if (kierunek_wy == pkg_naped::KIER_CW) begin
            kat_nast = (kat_aktualny == KAT_MAX) ? 9'd0 : kat_aktualny + 9'd1;
        end else begin
            kat_nast = (kat_aktualny == 9'd0) ? KAT_MAX : kat_aktualny - 9'd1;
        end
    end

    licznik_okresu #(
        .SZER(SZER_LICZ)
    ) u_licznik_okresu (
        .clk           (clk),
        .rst_n         (rst_n),
        .zaladuj       (zaladuj),
        .wlacz         (wlacz),
        .okres_we      (okres_nast),
        .koniec_stopnia(koniec_stopnia)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stan         <= pkg_naped::SPOCZYNEK;
            gotowy       <= 1'b1;
            krok         <= 1'b0;
            kierunek_wy  <= 1'b0;
            kat_aktualny <= 9'd0;
            koniec       <= 1'b0;
            wstrzymany   <= 1'b0;
            pozostalo    <= 9'd0;
        end else begin
            krok   <= 1'b0;
            koniec <= 1'b0;
            case (stan)
                pkg_naped::SPOCZYNEK: begin
                    gotowy <= 1'b1;
                    if (przyjmij) begin
                        gotowy      <= 1'b0;
                        kierunek_wy <= kierunek;
                        pozostalo   <= kat_obciety;
                        if (okres_ok) begin
                            stan <= pkg_naped::RUCH;
                        end else begin
                            stan       <= pkg_naped::PAUZA;
                            wstrzymany <= 1'b1;
                        end
                    end
                end
                pkg_naped::RUCH: begin
                    if (koniec_stopnia) begin
                        krok         <= 1'b1;
                        kat_aktualny <= kat_nast;
                        pozostalo    <= pozostalo - 9'd1;
                        if (pozostalo == 9'd1) begin
                            koniec <= 1'b1;
                            stan   <= pkg_naped::SPOCZYNEK;
                        end else if (!okres_ok) begin
                            stan       <= pkg_naped::PAUZA;
                            wstrzymany <= 1'b1;
                        end
                    end
                end
                pkg_naped::PAUZA: begin
                    if (okres_ok) begin
                        stan       <= pkg_naped::RUCH;
                        wstrzymany <= 1'b0;
                    end
                end
                default: begin
                    stan <= pkg_naped::SPOCZYNEK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generator_krokow_katowych.sv
// tb/tb_generator_krokow_katowych.sv - directed self-checking bench for generator_krokow_katowych
module tb_generator_krokow_katowych;
    import pkg_naped::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] taktowanie_na_stopien = 9'd21;
    logic       start = 1'b0;
    logic       kierunek = 1'b0;
    logic [8:0] kat_zadany = 9'd0;
    logic       gotowy;
    logic       krok;
    logic       kierunek_wy;
    logic [8:0] kat_aktualny;
    logic       koniec;
    logic       wstrzymany;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generator_krokow_katowych dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .taktowanie_na_stopien(taktowanie_na_stopien),
        .start                (start),
        .kierunek             (kierunek),
        .kat_zadany           (kat_zadany),
        .gotowy               (gotowy),
        .krok                 (krok),
        .kierunek_wy          (kierunek_wy),
        .kat_aktualny         (kat_aktualny),
        .koniec               (koniec),
        .wstrzymany           (wstrzymany)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gotowy"}, gotowy, 1);
        check({tag, "_krok"}, krok, 0);
        check({tag, "_kierunek_wy"}, kierunek_wy, 0);
        check({tag, "_kat"}, kat_aktualny, 0);
        check({tag, "_koniec"}, koniec, 0);
        check({tag, "_wstrzymany"}, wstrzymany, 0);
    endtask

    // Acceptance edge is the posedge right after the drive; t_acc is its cycle number.
    task automatic start_move(input logic dir, input logic [8:0] kat, output int t_acc);
        @(negedge clk);
        kierunek   = dir;
        kat_zadany = kat;
        start      = 1'b1;
        t_acc      = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_krok(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (krok) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic do_move(input string tag, input logic dir, input int kat, input int p,
                           input int n, input int exp_kat[8]);
        int t0, tprev, t;
        taktowanie_na_stopien = 9'(p);
        start_move(dir, 9'(kat), t0);
        check({tag, "_gotowy_zajety"}, gotowy, 0);
        tprev = t0;
        for (int i = 1; i <= n; i++) begin
            wait_krok(p + 5, t);
            check({tag, "_odstep"}, t - tprev, p);
            check({tag, "_kat"}, kat_aktualny, exp_kat[i-1]);
            check({tag, "_koniec"}, koniec, (i == n) ? 1 : 0);
            check({tag, "_kierunek_wy"}, kierunek_wy, dir);
            tprev = t;
        end
        check({tag, "_gotowy_przy_koncu"}, gotowy, 0);
        @(posedge clk);
        #1;
        check({tag, "_gotowy_po"}, gotowy, 1);
        check({tag, "_gotowy_cykl"}, cyc - t0, p * n + 1);
    endtask

    initial begin
        int t0, t, tr, cnt, seen_koniec;
        int e[8];

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_aktywny");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_values("reset_zwolniony");

`ifdef ROZRUCH_EN
        begin
            int sp[6];
            sp = '{50, 50, 50, 50, 25, 25};
            taktowanie_na_stopien = 9'd25;
            start_move(KIER_CW, 9'd6, t0);
            for (int i = 0; i < 6; i++) begin
                wait_krok(60, t);
                check("rampa_odstep", t - t0, sp[i]);
                check("rampa_kat", kat_aktualny, i + 1);
                t0 = t;
            end
            check("rampa_koniec", koniec, 1);
        end
`else
        e = '{1, 2, 3, 0, 0, 0, 0, 0};
        do_move("p21_kat3", KIER_CW, 3, 21, 3, e);

        e = '{2, 1, 0, 359, 358, 0, 0, 0};
        do_move("p1_ccw", KIER_CCW, 5, 1, 5, e);
        e = '{359, 0, 1, 2, 0, 0, 0, 0};
        do_move("cw_zawiniecie", KIER_CW, 4, 5, 4, e);
        e = '{1, 0, 359, 0, 0, 0, 0, 0};
        do_move("ccw_zawiniecie", KIER_CCW, 3, 5, 3, e);

        // Invalid period after the first step: degree 2 keeps its latched 40, then pause.
        taktowanie_na_stopien = 9'd40;
        start_move(KIER_CW, 9'd5, t0);
        wait_krok(50, t);
        check("pauza_krok1", t - t0, 40);
        check("pauza_kat1", kat_aktualny, 0);
        @(negedge clk);
        taktowanie_na_stopien = OKRES_NIEWAZNY;
        wait_krok(50, t);
        check("pauza_krok2", t - t0, 80);
        check("pauza_kat2", kat_aktualny, 1);
        check("pauza_wstrzymany", wstrzymany, 1);
        @(negedge clk);
        start = 1'b1; kierunek = KIER_CCW; kat_zadany = 9'd1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (krok) cnt++;
        end
        check("pauza_brak_krokow", cnt, 0);
        check("pauza_nadal", wstrzymany, 1);
        check("pauza_start_ignorowany", kierunek_wy, 1);
        check("pauza_kat_stoi", kat_aktualny, 1);
        @(negedge clk);
        taktowanie_na_stopien = 9'd22;
        tr = cyc + 1;
        wait_krok(30, t);
        check("wznowienie_odstep", t - tr, 22);
        check("wznowienie_wstrzymany", wstrzymany, 0);
        check("wznowienie_kat", kat_aktualny, 2);
        wait_krok(30, t);
        wait_krok(30, t);
        check("wznowienie_kat_koniec", kat_aktualny, 4);
        check("wznowienie_koniec", koniec, 1);
        @(posedge clk);
        #1;

        // Zero period at acceptance goes straight to pause.
        taktowanie_na_stopien = 9'd0;
        start_move(KIER_CW, 9'd1, t0);
        check("zero_wstrzymany", wstrzymany, 1);
        check("zero_gotowy", gotowy, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (krok) cnt++;
        end
        check("zero_brak_krokow", cnt, 0);
        @(negedge clk);
        taktowanie_na_stopien = 9'd2;
        tr = cyc + 1;
        wait_krok(10, t);
        check("zero_wznowienie", t - tr, 2);
        check("zero_kat", kat_aktualny, 5);
        check("zero_koniec", koniec, 1);
        @(posedge clk);
        #1;

        // kat_zadany=0 is ignored.
        taktowanie_na_stopien = 9'd1;
        start_move(KIER_CW, 9'd0, t0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (krok || koniec || !gotowy) cnt++;
            @(posedge clk);
            #1;
        end
        check("kat0_ignorowany", cnt, 0);
        check("kat0_kat", kat_aktualny, 5);

        // 500 is clipped to one full revolution.
        start_move(KIER_CW, 9'd500, t0);
        cnt = 0;
        seen_koniec = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (krok) cnt++;
            if (koniec) begin
                seen_koniec = 1;
                break;
            end
        end
        check("obrot_kroki", cnt, 360);
        check("obrot_koniec", seen_koniec, 1);
        check("obrot_kat", kat_aktualny, 5);
        @(posedge clk);
        #1;
        check("obrot_gotowy", gotowy, 1);

        // Asynchronous reset mid-move.
        taktowanie_na_stopien = 9'd33;
        start_move(KIER_CW, 9'd10, t0);
        for (int i = 0; i < 4; i++) wait_krok(40, t);
        check("reset_ruch_kat", kat_aktualny, 9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (krok || koniec || !gotowy) cnt++;
        end
        check("reset_bez_ruchu", cnt, 0);
        e = '{1, 2, 0, 0, 0, 0, 0, 0};
        do_move("po_resecie", KIER_CW, 2, 3, 2, e);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
